cmd_link_scheduler: RTL and testbench

- Sequences the command-to-JSON translator and UART link, and shares it among several command requesters: emergency stop, drive logic and operator override.
- Grants one request at a time and launches one frame per grant.
- Waits for the downstream link to finish, then enforces an inter-frame gap so the robot-side JSON parser is not overrun.
- Re-sends the last command as a heartbeat when the link has been idle too long.

---
 rtl/cmd_link_scheduler.sv | 162 ++++++++++++++++
 tb/tb_cmd_link_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_link_scheduler.sv
// Arbitrates command requesters onto a shared translator/UART link, launches one
// frame per grant, enforces an inter-frame gap and re-sends the last command as a heartbeat.
module cmd_link_scheduler #(
  parameter int                NUM_REQ          = 4,
  parameter int                CMD_W            = 3,
  parameter logic [CMD_W-1:0]  STOP_CMD         = 3'd7,
  parameter int                GAP_CYCLES       = 1000,
  parameter int                HEARTBEAT_CYCLES = 5000000,
  parameter int                ACK_TIMEOUT      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [CMD_W-1:0]           cmd_out,
  output logic                       cmd_start,
  input  logic                       link_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       hb_frame,
  output logic                       sched_busy,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int HB_W  = $clog2(HEARTBEAT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT);

  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W-1:0]  FIRST_RR = ID_W'(1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [CMD_W-1:0]  last_cmd;
  logic [ID_W-1:0]   rr_ptr;
  logic [HB_W-1:0]   hb_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  int                idx;
  logic              load_req, load_hb, to_set, gap_done;

  // Requester 0 overrides; others are searched upward from rr_ptr, wrapping 1..NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    if (req_valid[0]) begin
      win_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx = ((int'(rr_ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
        if (!win_found && req_valid[idx]) begin
          win_found = 1'b1;
          win_id    = ID_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    load_hb    = 1'b0;
    to_set     = 1'b0;
    gap_done   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          load_req   = 1'b1;
          state_next = START;
        end else if (hb_cnt == HB_LAST) begin
          load_hb    = 1'b1;
          state_next = START;
        end
      end
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (link_busy) begin
          state_next = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          to_set     = 1'b1;
          state_next = GAP;
        end
      end
      WAIT_DONE: if (!link_busy) state_next = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    if (state == START && !hb_frame) req_ack[grant_id] = 1'b1;
  end

  assign cmd_start  = (state == START);
  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_out     <= STOP_CMD;
      last_cmd    <= STOP_CMD;
      grant_id    <= '0;
      hb_frame    <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= FIRST_RR;
      hb_cnt      <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      if (load_req) begin
        cmd_out  <= req_cmd[int'(win_id)*CMD_W +: CMD_W];
        last_cmd <= req_cmd[int'(win_id)*CMD_W +: CMD_W];
        grant_id <= win_id;
        hb_frame <= 1'b0;
        if (win_id != '0) rr_ptr <= (win_id == LAST_ID) ? FIRST_RR : win_id + 1'b1;
      end else if (load_hb) begin
        cmd_out  <= last_cmd;
        hb_frame <= 1'b1;
      end else if (gap_done) begin
        hb_frame <= 1'b0;
      end

      if (to_set) timeout_err <= 1'b1;

      // Idle time only accumulates in IDLE; any launch restarts it.
      if (state_next == START) hb_cnt <= '0;
      else if (state == IDLE)  hb_cnt <= hb_cnt + 1'b1;

      if (state == WAIT_BUSY) to_cnt <= to_cnt + 1'b1;
      else                    to_cnt <= '0;

      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cmd_link_scheduler.sv
// Directed bench for cmd_link_scheduler with shortened gap/heartbeat timing and a
// simple link model that holds link_busy for link_len cycles after each cmd_start.
module tb_cmd_link_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CMD_W   = 3;
  localparam int GAP     = 20;
  localparam int HB      = 300;
  localparam int ACKTO   = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*CMD_W-1:0] req_cmd = '0;
  logic [NUM_REQ-1:0]       req_ack;
  logic [CMD_W-1:0]         cmd_out;
  logic                     cmd_start;
  logic                     link_busy = 1'b0;
  logic [1:0]               grant_id;
  logic                     hb_frame;
  logic                     sched_busy;
  logic                     timeout_err;

  int vectors = 0;
  int miscompares = 0;
  bit link_en = 1'b1;
  int link_len = 5;

  cmd_link_scheduler #(
    .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .STOP_CMD(3'd7),
    .GAP_CYCLES(GAP), .HEARTBEAT_CYCLES(HB), .ACK_TIMEOUT(ACKTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ack(req_ack), .cmd_out(cmd_out), .cmd_start(cmd_start),
    .link_busy(link_busy), .grant_id(grant_id), .hb_frame(hb_frame),
    .sched_busy(sched_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Link model: busy rises in the START cycle and stays high for link_len cycles.
  always @(negedge clk) begin
    if (cmd_start === 1'b1 && link_en) begin
      link_busy = 1'b1;
      repeat (link_len) @(negedge clk);
      link_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_start(output int n, input int bound, input string tag);
    n = 0;
    do begin step(); n++; end while (cmd_start !== 1'b1 && n < bound);
    if (cmd_start !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL %s_wait_start: no cmd_start within %0d cycles", tag, bound);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (sched_busy !== 1'b0 && n < 5000) begin step(); n++; end
    if (sched_busy !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL %s_wait_idle: scheduler never returned to idle", tag);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    step();
    vectors++; if (cmd_out !== 3'd7) begin miscompares++; $display("FAIL rst_cmd_out: got %0d want 7", cmd_out); end
    vectors++; if (cmd_start !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_start: got %b want 0", cmd_start); end
    vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL rst_sched_busy: got %b want 0", sched_busy); end
    vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ack: got %b want 0000", req_ack); end
    vectors++; if ({grant_id, hb_frame, timeout_err} !== 4'b0000) begin miscompares++; $display("FAIL rst_misc: got gid=%0d hb=%b to=%b want 0/0/0", grant_id, hb_frame, timeout_err); end
    rst_n = 1'b1;
    // First heartbeat launches HB cycles after release.
    wait_start(n, 2 * HB, "hb_first");
    vectors++; if (n !== HB) begin miscompares++; $display("FAIL hb_first_delay: got %0d want %0d", n, HB); end
    vectors++; if ({cmd_out, hb_frame, req_ack} !== {3'd7, 1'b1, 4'b0000}) begin miscompares++; $display("FAIL hb_first_frame: got cmd=%0d hb=%b ack=%b want 7/1/0000", cmd_out, hb_frame, req_ack); end
    wait_idle("hb_first");
    vectors++; if (hb_frame !== 1'b0) begin miscompares++; $display("FAIL hb_first_clear: got %b want 0", hb_frame); end
  endtask

  task automatic test_single();
    int n = 0;
    link_len = 25;
    req_cmd   = {3'd3, 3'd0, 3'd1, 3'd6};
    req_valid = 4'b0100;
    step();
    vectors++; if ({cmd_start, req_ack, cmd_out, grant_id, hb_frame} !== {1'b1, 4'b0100, 3'd0, 2'd2, 1'b0}) begin
      miscompares++; $display("FAIL single_grant: got st=%b ack=%b cmd=%0d gid=%0d hb=%b want 1/0100/0/2/0", cmd_start, req_ack, cmd_out, grant_id, hb_frame);
    end
    req_valid = 4'b0000;
    step(); n++;
    vectors++; if ({cmd_start, req_ack} !== 5'b0) begin miscompares++; $display("FAIL single_pulse: got st=%b ack=%b want 0/0000", cmd_start, req_ack); end
    repeat (10) begin step(); n++; end
    vectors++; if (cmd_out !== 3'd0) begin miscompares++; $display("FAIL single_hold: got %0d want 0", cmd_out); end
    while (sched_busy === 1'b1 && n < 200) begin step(); n++; end
    // START + 25 busy cycles + 1 cycle to see busy low + GAP.
    vectors++; if (n !== 26 + GAP) begin miscompares++; $display("FAIL single_frame_len: got %0d want %0d", n, 26 + GAP); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] exp_id [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    link_len  = 5;
    rst_n     = 1'b0;
    step();
    req_cmd   = {3'd3, 3'd2, 3'd1, 3'd6};
    req_valid = 4'b1110;
    rst_n     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(n, 200, "rr");
      vectors++; if ({grant_id, cmd_out, req_ack} !== {exp_id[k], 1'b0, exp_id[k], 4'(1) << exp_id[k]}) begin
        miscompares++; $display("FAIL rr_grant%0d: got gid=%0d cmd=%0d ack=%b want gid=%0d", k, grant_id, cmd_out, req_ack, exp_id[k]);
      end
      // START + 5 busy + 1 + GAP + 1 idle cycle between launches.
      if (k > 0) begin
        vectors++; if (n !== GAP + 7) begin miscompares++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, n, GAP + 7); end
      end
    end
    step(); step();
    req_valid = 4'b1111;
    wait_start(n, 200, "prio");
    vectors++; if ({grant_id, cmd_out, req_ack} !== {2'd0, 3'd6, 4'b0001}) begin
      miscompares++; $display("FAIL prio_grant0: got gid=%0d cmd=%0d ack=%b want 0/6/0001", grant_id, cmd_out, req_ack);
    end
    req_valid = 4'b1110;
    wait_start(n, 200, "prio_after");
    vectors++; if ({grant_id, cmd_out, req_ack} !== {2'd2, 3'd2, 4'b0100}) begin
      miscompares++; $display("FAIL prio_rr_resume: got gid=%0d cmd=%0d ack=%b want 2/2/0100", grant_id, cmd_out, req_ack);
    end
    req_valid = 4'b0000;
    wait_idle("rr");
  endtask

  task automatic test_timeout();
    int n;
    link_en   = 1'b0;
    req_valid = 4'b0001;
    step();
    vectors++; if ({cmd_start, req_ack} !== {1'b1, 4'b0001}) begin miscompares++; $display("FAIL to_launch: got st=%b ack=%b want 1/0001", cmd_start, req_ack); end
    req_valid = 4'b0000;
    repeat (ACKTO) step();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b want 0", timeout_err); end
    step();
    vectors++; if ({timeout_err, sched_busy} !== 2'b11) begin miscompares++; $display("FAIL to_set: got err=%b busy=%b want 1/1", timeout_err, sched_busy); end
    n = 1;
    while (sched_busy === 1'b1 && n < 200) begin step(); n++; end
    vectors++; if (n !== GAP + 1) begin miscompares++; $display("FAIL to_gap_len: got %0d want %0d", n, GAP + 1); end
    link_en   = 1'b1;
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    wait_idle("to_good");
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_hb_collision();
    int n;
    req_cmd = {3'd3, 3'd2, 3'd4, 3'd6};
    wait_idle("coll");
    repeat (HB - 1) step();
    req_valid = 4'b0010;
    step();
    vectors++; if ({cmd_start, hb_frame, req_ack, cmd_out} !== {1'b1, 1'b0, 4'b0010, 3'd4}) begin
      miscompares++; $display("FAIL coll_req_wins: got st=%b hb=%b ack=%b cmd=%0d want 1/0/0010/4", cmd_start, hb_frame, req_ack, cmd_out);
    end
    req_valid = 4'b0000;
    step();
    wait_idle("coll");
    wait_start(n, 2 * HB, "coll_hb");
    vectors++; if (n !== HB) begin miscompares++; $display("FAIL coll_hb_restart: got %0d want %0d", n, HB); end
    vectors++; if ({hb_frame, cmd_out, req_ack} !== {1'b1, 3'd4, 4'b0000}) begin
      miscompares++; $display("FAIL coll_hb_frame: got hb=%b cmd=%0d ack=%b want 1/4/0000", hb_frame, cmd_out, req_ack);
    end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL coll_sticky: got %b want 1", timeout_err); end
    wait_idle("coll_hb");
  endtask

  task automatic test_reset_mid_frame();
    bit spurious = 1'b0;
    link_len  = 25;
    req_cmd   = {3'd3, 3'd2, 3'd1, 3'd6};
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    vectors++; if ({cmd_out, cmd_start, sched_busy, req_ack} !== {3'd7, 1'b0, 1'b0, 4'b0000}) begin
      miscompares++; $display("FAIL rmid_async: got cmd=%0d st=%b busy=%b ack=%b want 7/0/0/0000", cmd_out, cmd_start, sched_busy, req_ack);
    end
    vectors++; if ({grant_id, hb_frame, timeout_err} !== 4'b0000) begin
      miscompares++; $display("FAIL rmid_misc: got gid=%0d hb=%b to=%b want 0/0/0", grant_id, hb_frame, timeout_err);
    end
    step();
    rst_n = 1'b1;
    repeat (30) begin
      step();
      if (cmd_start !== 1'b0 || sched_busy !== 1'b0) spurious = 1'b1;
    end
    vectors++; if (spurious !== 1'b0) begin miscompares++; $display("FAIL rmid_spurious: got activity=1 want 0"); end
    vectors++; if (cmd_out !== 3'd7) begin miscompares++; $display("FAIL rmid_cmd_out: got %0d want 7", cmd_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_hb_collision();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
